// File: rtl/psram_byte_bridge.sv
`default_nettype none
// ============================================================================
// Module   : psram_byte_bridge
// Brief    : Byte-wide host bus to 128-bit PSRAM burst command bridge, with a
//            one-line read buffer for repeated accesses to the same beat.
// Revision : 1.0 - initial release
// ============================================================================
module psram_byte_bridge #(
    parameter int ADDR_WIDTH  = 21,
    parameter int HOST_AW     = 23,
    parameter int BURST_BEATS = 4,
    parameter int CMD_GAP     = 14,
    parameter int RD_TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_calib,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [HOST_AW-1:0]    host_addr,
    input  logic [7:0]            host_wdata,
    output logic                  host_ready,
    output logic                  host_rvalid,
    output logic [7:0]            host_rdata,
    output logic                  cmd,
    output logic                  cmd_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [127:0]          wr_data,
    output logic [15:0]           data_mask,
    input  logic [127:0]          rd_data,
    input  logic                  rd_data_valid,
    output logic                  error
);

    localparam int c_TAG_W  = HOST_AW - 4;
    localparam int c_GAP_W  = $clog2(CMD_GAP + 1);
    localparam int c_TO_W   = $clog2(RD_TIMEOUT + 1);
    localparam int c_BEAT_W = $clog2(BURST_BEATS + 1);

    localparam logic [c_GAP_W-1:0]  c_GAP_LOAD  = c_GAP_W'(CMD_GAP - 1);
    localparam logic [c_TO_W-1:0]   c_TO_MAX    = c_TO_W'(RD_TIMEOUT);
    localparam logic [c_BEAT_W-1:0] c_BEATS_REM = c_BEAT_W'(BURST_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_CMD   = 3'd1,
        S_WR_BEAT  = 3'd2,
        S_RD_CMD   = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_RD_DRAIN = 3'd5
    } state_t;

    state_t                r_state;
    logic [c_GAP_W-1:0]    r_gap;
    logic [c_TO_W-1:0]     r_to;
    logic [c_BEAT_W-1:0]   r_beat;
    logic [3:0]            r_lane;
    logic [c_TAG_W-1:0]    r_tag;
    logic [127:0]          r_buf;
    logic [c_TAG_W-1:0]    r_buf_tag;
    logic                  r_buf_valid;
    logic                  r_rvalid;
    logic [7:0]            r_rdata;
    logic                  r_cmd;
    logic                  r_cmd_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [127:0]          r_wr_data;
    logic [15:0]           r_data_mask;
    logic                  r_error;

    logic [c_TAG_W-1:0]    w_tag;
    logic [3:0]            w_lane;
    logic                  w_accept;
    logic                  w_buf_hit;

    assign w_tag     = host_addr[HOST_AW-1:4];
    assign w_lane    = host_addr[3:0];
    assign w_buf_hit = r_buf_valid && (r_buf_tag == w_tag);
    // A pending read response (hit or timeout) blocks acceptance for that cycle.
    assign host_ready = (r_state == S_IDLE) && init_calib && (r_gap == '0) && !r_rvalid;
    assign w_accept   = host_req && host_ready;

    assign host_rvalid = r_rvalid;
    assign host_rdata  = r_rdata;
    assign cmd         = r_cmd;
    assign cmd_en      = r_cmd_en;
    assign addr        = r_addr;
    assign wr_data     = r_wr_data;
    assign data_mask   = r_data_mask;
    assign error       = r_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gap       <= '0;
            r_to        <= '0;
            r_beat      <= '0;
            r_lane      <= '0;
            r_tag       <= '0;
            r_buf       <= '0;
            r_buf_tag   <= '0;
            r_buf_valid <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_cmd       <= 1'b0;
            r_cmd_en    <= 1'b0;
            r_addr      <= '0;
            r_wr_data   <= '0;
            r_data_mask <= '0;
            r_error     <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            if (r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_lane <= w_lane;
                        r_tag  <= w_tag;
                        if (host_we) begin
                            r_state     <= S_WR_CMD;
                            r_cmd_en    <= 1'b1;
                            r_cmd       <= 1'b1;
                            r_addr      <= {w_tag, 2'b00};
                            r_wr_data   <= {16{host_wdata}};
                            r_data_mask <= ~(16'd1 << w_lane);
                            r_gap       <= c_GAP_LOAD;
                            if (w_buf_hit) begin
                                r_buf[{w_lane, 3'b000} +: 8] <= host_wdata;
                            end
                        end else if (w_buf_hit) begin
                            r_rvalid <= 1'b1;
                            r_rdata  <= r_buf[{w_lane, 3'b000} +: 8];
                        end else begin
                            r_state  <= S_RD_CMD;
                            r_cmd_en <= 1'b1;
                            r_cmd    <= 1'b0;
                            r_addr   <= {w_tag, 2'b00};
                            r_gap    <= c_GAP_LOAD;
                        end
                    end
                end

                S_WR_CMD: begin
                    r_cmd_en    <= 1'b0;
                    r_data_mask <= 16'hFFFF;
                    r_beat      <= c_BEATS_REM;
                    if (BURST_BEATS == 1) begin
                        r_state     <= S_IDLE;
                        r_cmd       <= 1'b0;
                        r_wr_data   <= '0;
                        r_data_mask <= '0;
                    end else begin
                        r_state <= S_WR_BEAT;
                    end
                end

                S_WR_BEAT: begin
                    if (r_beat <= c_BEAT_W'(1)) begin
                        r_state     <= S_IDLE;
                        r_cmd       <= 1'b0;
                        r_wr_data   <= '0;
                        r_data_mask <= '0;
                    end else begin
                        r_beat <= r_beat - 1'b1;
                    end
                end

                S_RD_CMD: begin
                    r_cmd_en <= 1'b0;
                    r_to     <= c_TO_W'(1);
                    r_state  <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    if (rd_data_valid) begin
                        r_buf       <= rd_data;
                        r_buf_tag   <= r_tag;
                        r_buf_valid <= 1'b1;
                        r_rvalid    <= 1'b1;
                        r_rdata     <= rd_data[{r_lane, 3'b000} +: 8];
                        r_beat      <= c_BEATS_REM;
                        r_state     <= (BURST_BEATS == 1) ? S_IDLE : S_RD_DRAIN;
                    end else if (r_to >= c_TO_MAX) begin
                        r_error     <= 1'b1;
                        r_rvalid    <= 1'b1;
                        r_rdata     <= 8'hFF;
                        r_buf_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
                end

                // Remaining beats of the burst carry nothing the host asked for.
                S_RD_DRAIN: begin
                    if (rd_data_valid) begin
                        if (r_beat <= c_BEAT_W'(1)) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_beat <= r_beat - 1'b1;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psram_byte_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_psram_byte_bridge
// Brief    : Self-checking bench: PSRAM byte-memory model, directed vectors,
//            hand sequences and randomized accesses against a reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psram_byte_bridge;

    localparam int ADDR_WIDTH  = 21;
    localparam int HOST_AW     = 23;
    localparam int BURST_BEATS = 4;
    localparam int CMD_GAP     = 14;
    localparam int RD_TIMEOUT  = 255;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  init_calib;
    logic                  host_req;
    logic                  host_we;
    logic [HOST_AW-1:0]    host_addr;
    logic [7:0]            host_wdata;
    logic                  host_ready;
    logic                  host_rvalid;
    logic [7:0]            host_rdata;
    logic                  cmd;
    logic                  cmd_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [127:0]          wr_data;
    logic [15:0]           data_mask;
    logic [127:0]          rd_data;
    logic                  rd_data_valid;
    logic                  error;

    psram_byte_bridge #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .HOST_AW    (HOST_AW),
        .BURST_BEATS(BURST_BEATS),
        .CMD_GAP    (CMD_GAP),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .init_calib   (init_calib),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ready   (host_ready),
        .host_rvalid  (host_rvalid),
        .host_rdata   (host_rdata),
        .cmd          (cmd),
        .cmd_en       (cmd_en),
        .addr         (addr),
        .wr_data      (wr_data),
        .data_mask    (data_mask),
        .rd_data      (rd_data),
        .rd_data_valid(rd_data_valid),
        .error        (error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Power-up content of the PSRAM, a few bytes pinned for the directed vectors.
    function automatic logic [7:0] def_byte(input int a);
        case (a)
            32:      return 8'hC3;
            37:      return 8'h96;
            31:      return 8'hE1;
            default: return 8'((a * 37) ^ (a >>> 9) ^ 8'h5C);
        endcase
    endfunction

    // ---------------- PSRAM controller model (byte memory) ----------------
    logic [7:0] pmem [int];
    bit respond    = 1'b1;
    int lat        = 2;
    int inject_req = 0;

    int cyc = 0, cmd_cnt = 0, last_cmd = -1, last_gap = 0, min_gap = 1000000;
    int w_left = 0, w_beat = 0, w_base = 0;
    int rd_left = 0, rd_beat = 0, rd_start = 0, rd_base = 0;
    int inject_done = 0;

    function automatic logic [7:0] mem_byte(input int a);
        return pmem.exists(a) ? pmem[a] : def_byte(a);
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            w_left        = 0;
            rd_left       = 0;
            rd_data_valid = 1'b0;
            rd_data       = '0;
        end else begin
            if (cmd_en) begin
                cmd_cnt++;
                if (last_cmd >= 0) begin
                    last_gap = cyc - last_cmd;
                    if (last_gap < min_gap) min_gap = last_gap;
                end
                last_cmd = cyc;
                if (cmd) begin
                    w_base = int'(addr) * 4;
                    w_beat = 0;
                    w_left = BURST_BEATS;
                end else if (respond) begin
                    rd_base  = int'(addr) * 4;
                    rd_beat  = 0;
                    rd_left  = BURST_BEATS;
                    rd_start = cyc + lat;
                end
            end
            if (w_left > 0) begin
                for (int i = 0; i < 16; i++)
                    if (!data_mask[i]) pmem[w_base + 16 * w_beat + i] = wr_data[8*i +: 8];
                w_beat++;
                w_left--;
            end
            if (rd_left > 0 && cyc >= rd_start) begin
                rd_data_valid = 1'b1;
                for (int i = 0; i < 16; i++)
                    rd_data[8*i +: 8] = mem_byte(rd_base + 16 * rd_beat + i);
                rd_beat++;
                rd_left--;
            end else if (inject_done < inject_req) begin
                rd_data_valid = 1'b1;
                rd_data       = {4{$urandom}};
                inject_done++;
            end else begin
                rd_data_valid = 1'b0;
                rd_data       = {4{$urandom}};
            end
        end
    end

    // ---------------- host-level reference ----------------
    logic [7:0] refm [int];
    bit ref_lv = 1'b0;
    int ref_lt = 0;

    task automatic ref_access(input bit we, input int a, input logic [7:0] d,
                              output logic [7:0] exp_rd, output int exp_cmd);
        exp_rd = 8'h00;
        if (we) begin
            refm[a] = d;
            exp_cmd = 1;
        end else begin
            exp_rd = refm.exists(a) ? refm[a] : def_byte(a);
            if (ref_lv && ref_lt == (a >> 4)) begin
                exp_cmd = 0;
            end else begin
                exp_cmd = 1;
                ref_lv  = 1'b1;
                ref_lt  = a >> 4;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One host access; returns read byte, commands issued and response latency.
    task automatic do_op(input bit we, input int a, input logic [7:0] d,
                         output logic [7:0] rd, output int ncmd, output int rlat, output bit rv);
        int n;
        int c0;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = HOST_AW'(a);
        host_wdata = d;
        n = 0;
        while (!host_ready && n < 100) begin
            step();
            n++;
        end
        chk("op_accept", host_ready, 1'b1);
        c0 = cmd_cnt;
        @(posedge clk);
        step();
        host_req = 1'b0;
        rd = 8'h00;
        rv = 1'b0;
        rlat = 0;
        if (!we) begin
            while (!host_rvalid && rlat < RD_TIMEOUT + 20) begin
                step();
                rlat++;
            end
            rv = host_rvalid;
            rd = host_rdata;
        end else begin
            repeat (BURST_BEATS) step();
        end
        step();
        ncmd = cmd_cnt - c0;
    endtask

    typedef struct {
        bit         we;
        int         a;
        logic [7:0] d;
        logic [7:0] exp_rd;
        int         exp_cmd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [7:0] rd, exp_rd;
        int ncmd, exp_cmd, rlat, n, c0;
        bit rv, seen;

        vecs[0] = '{1'b0, 32'h20, 8'h00, 8'hC3, 1};  // miss, lane 0
        vecs[1] = '{1'b0, 32'h25, 8'h00, 8'h96, 0};  // hit, lane 5
        vecs[2] = '{1'b1, 32'h25, 8'h77, 8'h00, 1};  // write-through
        vecs[3] = '{1'b0, 32'h25, 8'h00, 8'h77, 0};  // hit sees written byte
        vecs[4] = '{1'b0, 32'h13, 8'h00, 8'h5A, 1};  // miss, data from PSRAM
        vecs[5] = '{1'b0, 32'h1F, 8'h00, 8'hE1, 0};  // hit, lane 15

        rst = 1'b1; init_calib = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (3) step();
        chk("rst_ready_nocal", host_ready, 1'b0);
        chk("rst_cmd_en", cmd_en, 1'b0);
        chk("rst_rvalid", host_rvalid, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_mask", data_mask, 16'h0);
        chk("rst_wr_data", wr_data, 128'h0);
        init_calib = 1'b1;
        #1;
        chk("rst_ready_calib", host_ready, 1'b1);
        step();
        rst = 1'b0; init_calib = 1'b0;

        // Calibration gating followed by the lane-mask write.
        host_req = 1'b1; host_we = 1'b1; host_addr = HOST_AW'(32'h13); host_wdata = 8'h5A;
        c0 = cmd_cnt;
        repeat (8) step();
        chk("gate_ready", host_ready, 1'b0);
        chk("gate_no_cmd", cmd_cnt - c0, 0);
        init_calib = 1'b1;
        #1;
        chk("gate_ready_up", host_ready, 1'b1);
        @(posedge clk);
        step();
        host_req = 1'b0;
        ref_access(1'b1, 32'h13, 8'h5A, exp_rd, exp_cmd);
        chk("wr_cmd_en", cmd_en, 1'b1);
        chk("wr_cmd", cmd, 1'b1);
        chk("wr_addr", addr, 21'h4);
        chk("wr_mask_beat0", data_mask, 16'hFFF7);
        chk("wr_lane3", wr_data[31:24], 8'h5A);
        for (int b = 1; b < BURST_BEATS; b++) begin
            step();
            chk("wr_mask_beatn", data_mask, 16'hFFFF);
            chk("wr_cmd_en_low", cmd_en, 1'b0);
        end
        step();
        chk("wr_idle_mask", data_mask, 16'h0);

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].we, vecs[i].a, vecs[i].d, rd, ncmd, rlat, rv);
            ref_access(vecs[i].we, vecs[i].a, vecs[i].d, exp_rd, exp_cmd);
            chk($sformatf("vec%0d_cmds", i), ncmd, vecs[i].exp_cmd);
            if (!vecs[i].we) begin
                chk($sformatf("vec%0d_rvalid", i), rv, 1'b1);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
                if (vecs[i].exp_cmd == 0) chk($sformatf("vec%0d_hit_lat", i), rlat, 0);
            end
        end

        // Back-to-back writes: second command exactly CMD_GAP cycles later.
        do_op(1'b1, 32'h40, 8'h11, rd, ncmd, rlat, rv);
        ref_access(1'b1, 32'h40, 8'h11, exp_rd, exp_cmd);
        do_op(1'b1, 32'h41, 8'h22, rd, ncmd, rlat, rv);
        ref_access(1'b1, 32'h41, 8'h22, exp_rd, exp_cmd);
        chk("cmd_gap_exact", last_gap, CMD_GAP);

        // Randomized traffic against the reference.
        for (int i = 0; i < 60; i++) begin
            bit we;
            int a;
            logic [7:0] d;
            we  = ($urandom_range(0, 2) == 0);
            a   = $urandom_range(0, 127) + ($urandom_range(0, 3) << 16);
            d   = 8'($urandom);
            lat = $urandom_range(1, 8);
            do_op(we, a, d, rd, ncmd, rlat, rv);
            ref_access(we, a, d, exp_rd, exp_cmd);
            chk("rnd_cmds", ncmd, exp_cmd);
            if (!we) chk("rnd_rdata", {rv, rd}, {1'b1, exp_rd});
        end

        // Read timeout: PSRAM never answers.
        respond = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = HOST_AW'(32'h400);
        n = 0;
        while (!host_ready && n < 100) begin step(); n++; end
        @(posedge clk);
        step();
        host_req = 1'b0;
        chk("to_cmd_en", {cmd_en, cmd}, 2'b10);
        n = 1;
        while (!host_rvalid && n < RD_TIMEOUT + 20) begin step(); n++; end
        chk("to_latency", (n >= RD_TIMEOUT + 1) && (n <= RD_TIMEOUT + 3), 1'b1);
        chk("to_rdata", {host_rvalid, host_rdata}, {1'b1, 8'hFF});
        chk("to_error", error, 1'b1);
        step();
        chk("to_error_sticky", error, 1'b1);
        ref_lv = 1'b0;

        // Same line again must miss; reset it while waiting.
        host_req = 1'b1;
        n = 0;
        while (!host_ready && n < 100) begin step(); n++; end
        @(posedge clk);
        step();
        host_req = 1'b0;
        chk("rerd_cmd_en", cmd_en, 1'b1);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_error", error, 1'b0);
        chk("rst_mid_ready", host_ready, 1'b1);
        respond = 1'b1;
        c0 = cmd_cnt;
        inject_req = inject_req + 3;
        seen = 1'b0;
        repeat (10) begin
            step();
            seen = seen | host_rvalid;
        end
        chk("rst_mid_no_cmd", cmd_cnt - c0, 0);
        chk("stray_beats_ignored", seen, 1'b0);
        ref_lv = 1'b0;
        do_op(1'b0, 32'h13, 8'h00, rd, ncmd, rlat, rv);
        ref_access(1'b0, 32'h13, 8'h00, exp_rd, exp_cmd);
        chk("post_rst_cmds", ncmd, exp_cmd);
        chk("post_rst_rdata", {rv, rd}, {1'b1, exp_rd});

        chk("cmd_gap_min", min_gap >= CMD_GAP, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
